// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/flush controller and its stage registers.
// No logic; no latency; no backpressure.
// Types only, imported wherever these constants are needed.
package pipe_ctrl_pkg;

    localparam logic        CHIP_RST    = 1'b1;
    localparam logic        STAGE_CLEAR = 1'b1;
    localparam logic [31:0] NOP_PC      = 32'h0000_0000;
    localparam logic [31:0] NOP_INS     = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stall_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } clear_t;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running wrap-around event counter with synchronous reset and enable.
// Latency: count visible one cycle after the enabled edge.
// Backpressure: none; counts every enabled cycle.
module pipe_ctrl_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in == CHIP_RST) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard arbitration and flush control for the 5-stage pipeline, with perf counters.
// Latency: zero cycles input-to-control; one cycle for RUN/DRAIN transitions.
// Backpressure: rdy_in=0 freezes every stage and holds state and counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             id_load_use,
    input  logic             ex_jump,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             clear_if_id,
    output logic             clear_id_ex,
    output logic             clear_ex_mem,
    output logic             clear_mem_wb,
    output logic             pc_redirect,
    output logic             drain,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    state_t state_q;
    state_t state_d;
    stall_t stall;
    clear_t clear;
    logic   redirect;

    always_ff @(posedge clk_in) begin
        if (rst_in == CHIP_RST) begin
            state_q <= ST_RUN;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // A redirect while a fetch is outstanding leaves a wrong-path instruction in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (!mem_busy && ex_jump && if_busy) state_d = ST_DRAIN;
            ST_DRAIN: if (!if_busy) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall    = '0;
        clear    = '0;
        redirect = 1'b0;
        if (rst_in == CHIP_RST) begin
            clear = {4{STAGE_CLEAR}};
        end else if (!rdy_in) begin
            stall = '1;
        end else begin
            if (state_q == ST_DRAIN) begin
                clear.if_id = STAGE_CLEAR;
                stall.pc    = if_busy;
            end
            if (mem_busy) begin
                stall.pc     = 1'b1;
                stall.if_id  = 1'b1;
                stall.id_ex  = 1'b1;
                stall.ex_mem = 1'b1;
                clear.mem_wb = STAGE_CLEAR;
            end else if (ex_jump) begin
                redirect    = 1'b1;
                stall.pc    = 1'b0;
                clear.if_id = STAGE_CLEAR;
                clear.id_ex = STAGE_CLEAR;
            end else if (state_q == ST_RUN) begin
                if (id_load_use) begin
                    stall.pc    = 1'b1;
                    stall.if_id = 1'b1;
                    clear.id_ex = STAGE_CLEAR;
                end else if (if_busy) begin
                    stall.pc    = 1'b1;
                    clear.if_id = STAGE_CLEAR;
                end
            end
        end
    end

    assign stall_pc     = stall.pc;
    assign stall_if_id  = stall.if_id;
    assign stall_id_ex  = stall.id_ex;
    assign stall_ex_mem = stall.ex_mem;
    assign stall_mem_wb = stall.mem_wb;
    assign clear_if_id  = clear.if_id;
    assign clear_id_ex  = clear.id_ex;
    assign clear_ex_mem = clear.ex_mem;
    assign clear_mem_wb = clear.mem_wb;
    assign pc_redirect  = redirect;
    assign drain        = (state_q == ST_DRAIN) && (rst_in != CHIP_RST);

    pipe_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in && stall.pc),
        .cnt    (stall_cycles)
    );

    pipe_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in && redirect),
        .cnt    (flush_count)
    );

endmodule
